// File: rtl/urv_dmem_responder_if.sv
`default_nettype none
// urv_dmem_responder_if: uRV data-memory port bundle (CPU side = master, memory side = slave).
interface urv_dmem_responder_if;
  logic [31:0] dm_addr_i;
  logic [31:0] dm_data_s_i;
  logic [3:0]  dm_data_select_i;
  logic        dm_store_i;
  logic        dm_load_i;
  logic        err_clr_i;
  logic [31:0] dm_data_l_o;
  logic        dm_load_done_o;
  logic        dm_store_done_o;
  logic        err_o;

  modport master (
    output dm_addr_i, dm_data_s_i, dm_data_select_i, dm_store_i, dm_load_i, err_clr_i,
    input  dm_data_l_o, dm_load_done_o, dm_store_done_o, err_o
  );

  modport slave (
    input  dm_addr_i, dm_data_s_i, dm_data_select_i, dm_store_i, dm_load_i, err_clr_i,
    output dm_data_l_o, dm_load_done_o, dm_store_done_o, err_o
  );
endinterface
`default_nettype wire

// File: rtl/urv_dmem_responder.sv
`default_nettype none
// urv_dmem_responder (rev 1.0): wait-state data-memory responder with a one-deep pending buffer.
// Optional URV_DMEM_RANGE_CHECK_EN: out-of-window accesses complete but are suppressed and flag err_o.
module urv_dmem_responder #(
  parameter int g_addr_width  = 12,
  parameter int g_wait_states = 0
) (
  input  wire logic           clk_i,
  input  wire logic           rst_n_i,
  urv_dmem_responder_if.slave bus
);
  localparam int         c_words    = 1 << g_addr_width;
  localparam logic [3:0] c_wait_ld  = (g_wait_states == 0) ? 4'd0 : 4'(g_wait_states - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  sel;
    logic        is_store;
  } req_t;

  state_t      state, state_nxt;
  req_t        cur, cur_nxt, pend, pend_nxt, new_req, start_req, acc_req;
  logic        pend_vld, pend_vld_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        new_vld, start, access, overflow, acc_oor, err_set;
  logic [g_addr_width-1:0] acc_idx;
  logic [31:0] data_l;
  logic        load_done, store_done, err;
  logic [31:0] mem [c_words];
  logic        unused_addr_bits;

  always_comb begin
    state_nxt    = state;
    cur_nxt      = cur;
    pend_nxt     = pend;
    pend_vld_nxt = pend_vld;
    cnt_nxt      = cnt;
    start        = 1'b0;
    access       = 1'b0;
    overflow     = 1'b0;
    new_vld      = bus.dm_load_i | bus.dm_store_i;
    // is_store taken straight from dm_store_i makes a simultaneous store win over a load
    new_req      = '{addr: bus.dm_addr_i, data: bus.dm_data_s_i,
                     sel: bus.dm_data_select_i, is_store: bus.dm_store_i};
    start_req    = new_req;
    acc_req      = cur;

    case (state)
      IDLE: start = new_vld;
      WAIT: begin
        if (cnt == 4'd0) begin
          state_nxt = RESP;
          access    = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
        if (new_vld) begin
          if (!pend_vld) begin
            pend_vld_nxt = 1'b1;
            pend_nxt     = new_req;
          end else begin
            overflow = 1'b1;
          end
        end
      end
      RESP: begin
        state_nxt = IDLE;
        if (pend_vld) begin
          start        = 1'b1;
          start_req    = pend;
          pend_vld_nxt = new_vld;
          pend_nxt     = new_req;
        end else begin
          start = new_vld;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // The memory access is performed on the edge entering RESP, so the done cycle sees its result
    if (start) begin
      cur_nxt = start_req;
      if (g_wait_states == 0) begin
        state_nxt = RESP;
        access    = 1'b1;
        acc_req   = start_req;
      end else begin
        state_nxt = WAIT;
        cnt_nxt   = c_wait_ld;
      end
    end
  end

  assign acc_idx = acc_req.addr[g_addr_width+1:2];

`ifdef URV_DMEM_RANGE_CHECK_EN
  assign acc_oor          = |acc_req.addr[31:g_addr_width+2];
  assign unused_addr_bits = ^acc_req.addr[1:0];
`else
  assign acc_oor          = 1'b0;
  assign unused_addr_bits = ^{acc_req.addr[31:g_addr_width+2], acc_req.addr[1:0]};
`endif

  assign err_set = overflow | (access & acc_oor);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state      <= IDLE;
      cur        <= '0;
      pend       <= '0;
      pend_vld   <= 1'b0;
      cnt        <= 4'd0;
      data_l     <= 32'd0;
      load_done  <= 1'b0;
      store_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_nxt;
      cur        <= cur_nxt;
      pend       <= pend_nxt;
      pend_vld   <= pend_vld_nxt;
      cnt        <= cnt_nxt;
      load_done  <= access & ~acc_req.is_store;
      store_done <= access &  acc_req.is_store;
      if (access && !acc_req.is_store)
        data_l <= acc_oor ? 32'd0 : mem[acc_idx];
      if (err_set)
        err <= 1'b1;
      else if (bus.err_clr_i)
        err <= 1'b0;
    end
  end

  // RAM has no reset; the rst_n_i term keeps a request seen during reset from writing
  always_ff @(posedge clk_i) begin
    if (rst_n_i && access && acc_req.is_store && !acc_oor) begin
      for (int b = 0; b < 4; b++) begin
        if (acc_req.sel[b])
          mem[acc_idx][8*b +: 8] <= acc_req.data[8*b +: 8];
      end
    end
  end

  assign bus.dm_data_l_o     = data_l;
  assign bus.dm_load_done_o  = load_done;
  assign bus.dm_store_done_o = store_done;
  assign bus.err_o           = err;

endmodule
`default_nettype wire

// File: tb/tb_urv_dmem_responder.sv
`default_nettype none
`timescale 1ns/1ps
// tb_urv_dmem_responder: vector table, wait-state/overflow/reset sequences and a randomized model check.
module tb_urv_dmem_responder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

`ifdef URV_DMEM_RANGE_CHECK_EN
  localparam bit range_en = 1'b1;
`else
  localparam bit range_en = 1'b0;
`endif

  urv_dmem_responder_if bus0();
  urv_dmem_responder_if bus3();

  urv_dmem_responder #(.g_addr_width(12), .g_wait_states(0)) dut0 (
    .clk_i(clk), .rst_n_i(rst_n), .bus(bus0));
  urv_dmem_responder #(.g_addr_width(12), .g_wait_states(3)) dut3 (
    .clk_i(clk), .rst_n_i(rst_n), .bus(bus3));

  int checks = 0;
  int passed = 0;

  typedef struct {
    logic        ld, st;
    logic [31:0] addr, data;
    logic [3:0]  sel;
    logic        e_ld, e_sd;
    logic [31:0] e_data;
  } vec_t;

  typedef struct {
    logic        is_store;
    logic [31:0] addr, data;
    logic [3:0]  sel;
  } mreq_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic drive(input int k, input logic ld, input logic st, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] sel, input logic clr);
    if (k == 0) begin
      bus0.dm_load_i = ld; bus0.dm_store_i = st; bus0.dm_addr_i = a;
      bus0.dm_data_s_i = d; bus0.dm_data_select_i = sel; bus0.err_clr_i = clr;
    end else begin
      bus3.dm_load_i = ld; bus3.dm_store_i = st; bus3.dm_addr_i = a;
      bus3.dm_data_s_i = d; bus3.dm_data_select_i = sel; bus3.err_clr_i = clr;
    end
  endtask

  task automatic get(input int k, output logic ld, output logic sd, output logic [31:0] d, output logic e);
    if (k == 0) begin
      ld = bus0.dm_load_done_o; sd = bus0.dm_store_done_o; d = bus0.dm_data_l_o; e = bus0.err_o;
    end else begin
      ld = bus3.dm_load_done_o; sd = bus3.dm_store_done_o; d = bus3.dm_data_l_o; e = bus3.err_o;
    end
  endtask

  // One request, then wait (bounded) for its done pulse; returns at a negedge with the DUT idle.
  task automatic single(input int k, input logic ld, input logic st, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] sel,
                        output logic ld_seen, output logic sd_seen, output logic [31:0] dq, output logic e);
    logic l, s, er;
    logic [31:0] dd;
    drive(k, ld, st, a, d, sel, 1'b0);
    @(negedge clk);
    drive(k, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0);
    ld_seen = 1'b0; sd_seen = 1'b0; dq = 32'd0; e = 1'b0;
    for (int i = 0; i < 20; i++) begin
      get(k, l, s, dd, er);
      if (l || s) begin
        ld_seen = l; sd_seen = s; dq = dd; e = er;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic clear_err(input int k);
    drive(k, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b1);
    @(negedge clk);
    drive(k, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0);
  endtask

  function automatic logic is_oor(input logic [31:0] a);
    return range_en && (a[31:14] != 18'd0);
  endfunction

  // Reference model: requests are tracked by their completion cycle (accept cycle + 1 + w).
  task automatic run_random(input int k, input int w, input int n, input int pct);
    logic [31:0] mm [16];
    mreq_t       svc, nr;
    mreq_t       pq[$];
    logic        svc_v, nv, ovf, oor, clr, ld, st;
    int          svc_done;
    logic        e_ld, e_sd, e_err, l, s, er, ls, ss, ee;
    logic [31:0] e_data, dd, addr;
    logic [3:0]  idx, sel;
    logic [17:0] up;

    for (int i = 0; i < 16; i++) begin
      mm[i] = $urandom;
      single(k, 1'b0, 1'b1, 32'(i) << 2, mm[i], 4'hF, ls, ss, dd, ee);
      if (i < 2) check($sformatf("rand_w%0d_init_sd%0d", w, i), {ls, ss}, 2'b01);
    end
    single(k, 1'b1, 1'b0, 32'h0, 32'd0, 4'd0, ls, ss, dd, ee);
    check($sformatf("rand_w%0d_init_load", w), {ls, dd}, {1'b1, mm[0]});
    clear_err(k);

    e_ld = 1'b0; e_sd = 1'b0; e_err = 1'b0; e_data = mm[0];
    svc_v = 1'b0; svc_done = 0; svc = '{default: '0};
    for (int c = 0; c < n; c++) begin
      get(k, l, s, dd, er);
      check($sformatf("rand_w%0d_c%0d", w, c), {l, s, er, dd}, {e_ld, e_sd, e_err, e_data});

      ld = 1'b0; st = 1'b0;
      if ($urandom_range(0, 99) < pct) begin
        case ($urandom_range(0, 9))
          0:          begin ld = 1'b1; st = 1'b1; end
          1, 2, 3, 4: st = 1'b1;
          default:    ld = 1'b1;
        endcase
      end
      idx  = 4'($urandom_range(0, 15));
      up   = ($urandom_range(0, 3) == 0) ? 18'($urandom) : 18'd0;
      addr = {up, 8'd0, idx, 2'($urandom)};
      sel  = 4'($urandom);
      clr  = ($urandom_range(0, 99) < 3);
      nr   = '{is_store: st, addr: addr, data: $urandom, sel: sel};
      drive(k, ld, st, addr, nr.data, sel, clr);

      nv  = ld | st;
      ovf = 1'b0;
      if (svc_v && svc_done == c) begin
        if (pq.size() > 0) begin
          svc = pq.pop_front(); svc_done = c + 1 + w;
          if (nv) pq.push_back(nr);
        end else if (nv) begin
          svc = nr; svc_done = c + 1 + w;
        end else begin
          svc_v = 1'b0;
        end
      end else if (!svc_v) begin
        if (nv) begin svc = nr; svc_v = 1'b1; svc_done = c + 1 + w; end
      end else if (nv) begin
        if (pq.size() == 0) pq.push_back(nr);
        else ovf = 1'b1;
      end

      e_ld = 1'b0; e_sd = 1'b0; oor = 1'b0;
      if (svc_v && svc_done == c + 1) begin
        oor = is_oor(svc.addr);
        // generated addresses keep bits 13:6 zero, so bits 5:2 select the word
        if (svc.is_store) begin
          e_sd = 1'b1;
          if (!oor)
            for (int b = 0; b < 4; b++)
              if (svc.sel[b]) mm[svc.addr[5:2]][8*b +: 8] = svc.data[8*b +: 8];
        end else begin
          e_ld   = 1'b1;
          e_data = oor ? 32'd0 : mm[svc.addr[5:2]];
        end
      end
      e_err = (ovf || oor) ? 1'b1 : (clr ? 1'b0 : e_err);
      @(negedge clk);
    end
    drive(k, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0);
    repeat (20) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t        tv[11];
    logic        l, s, er, ls, ss, ee, e2, e3, errseen;
    logic [31:0] dd;
    int          first, second, nld, nsd;

    drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0);
    drive(3, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0);
    repeat (3) @(negedge clk);
    get(0, l, s, dd, er);
    check("reset_w0", {l, s, er, dd}, 35'd0);
    get(3, l, s, dd, er);
    check("reset_w3", {l, s, er, dd}, 35'd0);
    rst_n = 1'b1;
    @(negedge clk);

    tv[0]  = '{1'b0, 1'b1, 32'h10, 32'h12345678, 4'hF, 1'b0, 1'b1, 32'h00000000};
    tv[1]  = '{1'b0, 1'b0, 32'h00, 32'h00000000, 4'h0, 1'b0, 1'b0, 32'h00000000};
    tv[2]  = '{1'b1, 1'b0, 32'h10, 32'h00000000, 4'h0, 1'b1, 1'b0, 32'h12345678};
    tv[3]  = '{1'b0, 1'b1, 32'h10, 32'h0000AB00, 4'h2, 1'b0, 1'b1, 32'h12345678};
    tv[4]  = '{1'b1, 1'b0, 32'h10, 32'h00000000, 4'h0, 1'b1, 1'b0, 32'h1234AB78};
    tv[5]  = '{1'b0, 1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 1'b0, 1'b1, 32'h1234AB78};
    tv[6]  = '{1'b0, 1'b1, 32'h20, 32'h11223344, 4'h5, 1'b0, 1'b1, 32'h1234AB78};
    tv[7]  = '{1'b1, 1'b0, 32'h20, 32'h00000000, 4'h0, 1'b1, 1'b0, 32'hCA22F044};
    tv[8]  = '{1'b1, 1'b1, 32'h20, 32'hFFFFFFFF, 4'h8, 1'b0, 1'b1, 32'hCA22F044};
    tv[9]  = '{1'b1, 1'b0, 32'h20, 32'h00000000, 4'h0, 1'b1, 1'b0, 32'hFF22F044};
    tv[10] = '{1'b0, 1'b0, 32'h00, 32'h00000000, 4'h0, 1'b0, 1'b0, 32'hFF22F044};
    for (int i = 0; i < 11; i++) begin
      drive(0, tv[i].ld, tv[i].st, tv[i].addr, tv[i].data, tv[i].sel, 1'b0);
      @(negedge clk);
      get(0, l, s, dd, er);
      check($sformatf("vec%0d", i), {l, s, er, dd}, {tv[i].e_ld, tv[i].e_sd, 1'b0, tv[i].e_data});
    end
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0);
    @(negedge clk);

    // Three wait states: loads at T and T+2, the second is buffered
    single(3, 1'b0, 1'b1, 32'h10, 32'hA5A5A5A5, 4'hF, ls, ss, dd, ee);
    check("w3_prime_store", {ls, ss}, 2'b01);
    first = -1; second = -1; nld = 0; nsd = 0; errseen = 1'b0;
    for (int j = 0; j < 12; j++) begin
      get(3, l, s, dd, er);
      if (l) begin
        nld++;
        if (first < 0) first = j; else second = j;
        check($sformatf("w3_load_data_c%0d", j), dd, 32'hA5A5A5A5);
      end
      if (s) nsd++;
      if (er) errseen = 1'b1;
      drive(3, (j == 0 || j == 2), 1'b0, 32'h10, 32'd0, 4'd0, 1'b0);
      @(negedge clk);
    end
    drive(3, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0);
    check("w3_first_done_cycle", 64'(first), 64'd4);
    check("w3_second_done_cycle", 64'(second), 64'd8);
    check("w3_load_done_count", 64'(nld), 64'd2);
    check("w3_store_done_count", 64'(nsd), 64'd0);
    check("w3_no_err", errseen, 1'b0);

    // Overflow: third back-to-back request is dropped
    nld = 0; e2 = 1'bx; e3 = 1'bx;
    for (int j = 0; j < 14; j++) begin
      get(3, l, s, dd, er);
      if (l || s) nld++;
      if (j == 2) e2 = er;
      if (j == 3) e3 = er;
      drive(3, (j < 3), 1'b0, 32'h10, 32'd0, 4'd0, 1'b0);
      @(negedge clk);
    end
    drive(3, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0);
    check("ovf_done_count", 64'(nld), 64'd2);
    check("ovf_err_before", e2, 1'b0);
    check("ovf_err_set", e3, 1'b1);
    get(3, l, s, dd, er);
    check("ovf_err_sticky", er, 1'b1);
    clear_err(3);
    get(3, l, s, dd, er);
    check("ovf_err_cleared", er, 1'b0);

    // Reset in the middle of a store's wait states
    drive(3, 1'b0, 1'b1, 32'h10, 32'h0BADF00D, 4'hF, 1'b0);
    @(negedge clk);
    drive(3, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    get(3, l, s, dd, er);
    check("rst_outputs_zero", {l, s, er, dd}, 35'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    nsd = 0;
    for (int j = 0; j < 8; j++) begin
      get(3, l, s, dd, er);
      if (l || s) nsd++;
      @(negedge clk);
    end
    check("rst_no_done", 64'(nsd), 64'd0);
    single(3, 1'b1, 1'b0, 32'h10, 32'd0, 4'd0, ls, ss, dd, ee);
    check("rst_old_contents", {ls, dd}, {1'b1, 32'hA5A5A5A5});

    // Address beyond the 16 KiB window
    single(0, 1'b0, 1'b1, 32'h0, 32'h5555AAAA, 4'hF, ls, ss, dd, ee);
    check("range_prime_store", {ls, ss}, 2'b01);
    single(0, 1'b1, 1'b0, 32'h00010000, 32'd0, 4'd0, ls, ss, dd, ee);
    check("range_load_done", ls, 1'b1);
    check("range_load_data", dd, range_en ? 32'h0 : 32'h5555AAAA);
    check("range_err", ee, range_en);
    clear_err(0);
    get(0, l, s, dd, er);
    check("range_err_cleared", er, 1'b0);

    run_random(0, 0, 400, 60);
    run_random(3, 3, 600, 40);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
`default_nettype wire
